// File: rtl/ca_pkg.sv
// ca_pkg: register-file geometry and dump FSM states shared with RegFile and regfile_dump
package ca_pkg;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} dump_state_t;
endpackage

// File: rtl/RegFile.sv
// RegFile: 32-entry register file, one synchronous write port, two combinational read ports
module RegFile
    import ca_pkg::*;
(
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [REG_DATA_W-1:0] write_data,
    input  logic [REG_ADDR_W-1:0] read_reg1,
    output logic [REG_DATA_W-1:0] read_data1,
    input  logic [REG_ADDR_W-1:0] read_reg2,
    output logic [REG_DATA_W-1:0] read_data2
);
    logic [REG_DATA_W-1:0] regs [REG_COUNT];

    assign read_data1 = regs[read_reg1];
    assign read_data2 = regs[read_reg2];

    always_ff @(posedge clk)
        if (write_en) regs[write_reg] <= write_data;
endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: walks a wrap-around register range and streams {index, value} beats with count and XOR checksum
module regfile_dump
    import ca_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_reg,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   beat_count,
    output logic [DATA_W-1:0] checksum
);
    dump_state_t       state, next_state;
    logic [ADDR_W-1:0] ptr, last_ptr;
    logic              accept;

    assign rf_read_reg = ptr;
    assign out_valid   = state == HOLD;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign accept      = out_valid && out_ready;

    always_comb begin
        next_state = (state == IDLE) ? (start ? READ : IDLE) :
                     (state == READ) ? HOLD :
                     (state == HOLD) ? (out_ready ? (ptr == last_ptr ? DONE : READ) : HOLD) :
                     IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            last_ptr   <= '0;
            out_reg    <= '0;
            out_data   <= '0;
            beat_count <= '0;
            checksum   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                ptr        <= first_reg;
                last_ptr   <= last_reg;
                beat_count <= '0;
                checksum   <= '0;
            end
            if (state == READ) begin
                out_reg  <= ptr;
                out_data <= rf_read_data;
            end
            if (accept) begin
                checksum   <= checksum ^ out_data;
                beat_count <= beat_count + (ADDR_W+1)'(1);
                // pointer stays on the last index so rf_read_reg is stable through DONE
                if (ptr != last_ptr) ptr <= ptr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard bench driving regfile_dump against a live RegFile
module tb_regfile_dump;
    logic        clk = 0, reset = 1, start = 0, out_ready = 1, wr_en = 0;
    logic [4:0]  first_reg = 0, last_reg = 0, wr_reg = 0, rf_read_reg, out_reg;
    logic [31:0] wr_data = 0, rf_read_data, out_data, checksum, unused_rd2;
    logic        out_valid, busy, done;
    logic [5:0]  beat_count;
    logic [31:0] model [32];
    logic [36:0] sb [$];
    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    regfile_dump dut (
        .clk(clk), .reset(reset), .start(start), .first_reg(first_reg), .last_reg(last_reg),
        .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_reg(out_reg), .out_data(out_data), .busy(busy),
        .done(done), .beat_count(beat_count), .checksum(checksum)
    );

    RegFile rf (
        .clk(clk), .write_en(wr_en), .write_reg(wr_reg), .write_data(wr_data),
        .read_reg1(rf_read_reg), .read_data1(rf_read_data), .read_reg2(5'd0), .read_data2(unused_rd2)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_rf(input logic [4:0] idx, input logic [31:0] val);
        wr_en = 1; wr_reg = idx; wr_data = val;
        step();
        wr_en = 0;
        model[idx] = val;
    endtask

    task automatic push_range(input logic [4:0] f, input logic [4:0] l);
        logic [4:0] i;
        i = f;
        forever begin
            sb.push_back({i, model[i]});
            if (i == l) break;
            i++;
        end
    endtask

    task automatic kick(input logic [4:0] f, input logic [4:0] l);
        start = 1; first_reg = f; last_reg = l;
        step();
        start = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        compared++;
        if ({out_valid, busy, done, out_reg, out_data, rf_read_reg, beat_count, checksum} !== '0) begin
            mismatched++;
            $display("FAIL reset_values: valid=%b busy=%b done=%b reg=%0d data=%h rd=%0d cnt=%0d cs=%h, all required 0",
                     out_valid, busy, done, out_reg, out_data, rf_read_reg, beat_count, checksum);
        end
        reset = 0;
    endtask

    task automatic test_basic();
        write_rf(0, 0); write_rf(1, 55); write_rf(2, 7); write_rf(3, 9);
        out_ready = 1;
        push_range(0, 3);
        kick(0, 3);
        for (int c = 1; c <= 9; c++) begin
            compared++;
            if (out_valid !== (c % 2 == 0 && c <= 8) || done !== (c == 9)) begin
                mismatched++;
                $display("FAIL basic_timing at N+%0d: valid=%b done=%b, required valid=%b done=%b",
                         c, out_valid, done, (c % 2 == 0 && c <= 8), (c == 9));
            end
            if (out_valid) begin
                compared++;
                if (sb.size() == 0 || {out_reg, out_data} !== sb[0]) begin
                    mismatched++;
                    $display("FAIL basic_beat: got r%0d=%0d, required %h", out_reg, out_data, sb.size() ? sb[0] : 37'd0);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
            if (c == 9) begin
                compared++;
                if (beat_count !== 6'd4 || checksum !== 32'd57) begin
                    mismatched++;
                    $display("FAIL basic_totals: count=%0d checksum=%0d, required 4 and 57", beat_count, checksum);
                end
            end
            step();
        end
    endtask

    task automatic test_wrap();
        bit fin = 0;
        out_ready = 1;
        push_range(30, 1);
        kick(30, 1);
        for (int c = 1; c <= 20 && !fin; c++) begin
            if (out_valid) begin
                compared++;
                if (sb.size() == 0 || {out_reg, out_data} !== sb[0]) begin
                    mismatched++;
                    $display("FAIL wrap_beat: got r%0d=%h, required %h", out_reg, out_data, sb.size() ? sb[0] : 37'd0);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
            if (done) begin
                fin = 1;
                compared++;
                if (beat_count !== 6'd4 || sb.size() != 0) begin
                    mismatched++;
                    $display("FAIL wrap_done: count=%0d left=%0d, required 4 and 0", beat_count, sb.size());
                end
            end
            step();
        end
        if (!fin) begin mismatched++; $display("FAIL wrap_timeout: done=0, required done within 20 cycles"); end
    endtask

    task automatic test_full();
        bit fin = 0;
        logic [4:0] prev = 0;
        bit seen = 0;
        out_ready = 1;
        push_range(5, 4);
        kick(5, 4);
        for (int c = 1; c <= 80 && !fin; c++) begin
            if (out_valid) begin
                compared++;
                if (sb.size() == 0 || {out_reg, out_data} !== sb[0]) begin
                    mismatched++;
                    $display("FAIL full_beat: got r%0d=%h, required %h", out_reg, out_data, sb.size() ? sb[0] : 37'd0);
                end
                if (sb.size() != 0) void'(sb.pop_front());
                if (seen && prev == 31) begin
                    compared++;
                    if (out_reg !== 5'd0) begin mismatched++; $display("FAIL full_wrap: reg after 31 is %0d, required 0", out_reg); end
                end
                prev = out_reg; seen = 1;
            end
            if (done) begin
                fin = 1;
                compared++;
                if (beat_count !== 6'd32 || sb.size() != 0 || c != 65) begin
                    mismatched++;
                    $display("FAIL full_done: count=%0d left=%0d at N+%0d, required 32, 0, N+65", beat_count, sb.size(), c);
                end
            end
            step();
        end
        if (!fin) begin mismatched++; $display("FAIL full_timeout: done=0, required done within 80 cycles"); end
    endtask

    task automatic test_backpressure();
        bit fin = 0;
        int st = 0;
        out_ready = 1;
        push_range(0, 3);
        kick(0, 3);
        for (int c = 1; c <= 40 && !fin; c++) begin
            if (st > 0 && st < 5 && !out_valid) begin
                compared++; mismatched++;
                $display("FAIL bp_valid_drop: valid=0 during stall cycle %0d, required 1", st);
            end
            if (out_valid && out_reg == 1 && st < 5) begin
                compared++;
                if (out_data !== 32'd55) begin mismatched++; $display("FAIL bp_hold: data=%0d during stall, required 55", out_data); end
                st++;
                out_ready = 0;
            end else begin
                out_ready = 1;
                if (out_valid) begin
                    compared++;
                    if (sb.size() == 0 || {out_reg, out_data} !== sb[0]) begin
                        mismatched++;
                        $display("FAIL bp_beat: got r%0d=%0d, required %h", out_reg, out_data, sb.size() ? sb[0] : 37'd0);
                    end
                    if (sb.size() != 0) void'(sb.pop_front());
                end
            end
            if (done) begin
                fin = 1;
                compared++;
                if (beat_count !== 6'd4 || checksum !== 32'd57 || sb.size() != 0 || st != 5) begin
                    mismatched++;
                    $display("FAIL bp_done: count=%0d cs=%0d left=%0d stalls=%0d, required 4, 57, 0, 5",
                             beat_count, checksum, sb.size(), st);
                end
            end
            step();
        end
        out_ready = 1;
        if (!fin) begin mismatched++; $display("FAIL bp_timeout: done=0, required done within 40 cycles"); end
    endtask

    task automatic test_busy_start();
        bit fin = 0;
        out_ready = 1;
        push_range(0, 3);
        kick(0, 3);
        for (int c = 1; c <= 20 && !fin; c++) begin
            compared++;
            if (busy !== 1'b1) begin mismatched++; $display("FAIL busy_level: busy=%b at N+%0d, required 1", busy, c); end
            if (out_valid) begin
                compared++;
                if (sb.size() == 0 || {out_reg, out_data} !== sb[0]) begin
                    mismatched++;
                    $display("FAIL busy_beat: got r%0d=%h, required %h", out_reg, out_data, sb.size() ? sb[0] : 37'd0);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
            if (done) begin
                fin = 1;
                start = 0;
                compared++;
                if (beat_count !== 6'd4 || sb.size() != 0) begin
                    mismatched++;
                    $display("FAIL busy_done: count=%0d left=%0d, required 4 and 0", beat_count, sb.size());
                end
            end else begin
                start = 1; first_reg = 10; last_reg = 20;
            end
            step();
        end
        start = 0;
        if (!fin) begin mismatched++; $display("FAIL busy_timeout: done=0, required done within 20 cycles"); end
        step();
        compared++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_idle: busy=%b valid=%b after dump, required 0 and 0", busy, out_valid);
        end
    endtask

    task automatic test_write_hold();
        bit fin = 0;
        out_ready = 1;
        sb.push_back({5'd0, model[0]});
        sb.push_back({5'd1, model[1]});
        sb.push_back({5'd2, 32'd99});
        sb.push_back({5'd3, model[3]});
        kick(0, 3);
        for (int c = 1; c <= 20 && !fin; c++) begin
            wr_en = 0;
            if (out_valid) begin
                compared++;
                if (sb.size() == 0 || {out_reg, out_data} !== sb[0]) begin
                    mismatched++;
                    $display("FAIL wr_beat: got r%0d=%0d, required %h", out_reg, out_data, sb.size() ? sb[0] : 37'd0);
                end
                if (sb.size() != 0) void'(sb.pop_front());
                if (out_reg == 1) begin
                    wr_en = 1; wr_reg = 2; wr_data = 99; model[2] = 99;
                end
            end
            if (done) begin
                fin = 1;
                compared++;
                if (beat_count !== 6'd4 || sb.size() != 0) begin
                    mismatched++;
                    $display("FAIL wr_done: count=%0d left=%0d, required 4 and 0", beat_count, sb.size());
                end
            end
            step();
        end
        wr_en = 0;
        if (!fin) begin mismatched++; $display("FAIL wr_timeout: done=0, required done within 20 cycles"); end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        out_ready = 0;
        kick(0, 3);
        for (int c = 1; c <= 5 && !hit; c++) begin
            if (out_valid) hit = 1;
            else step();
        end
        if (!hit) begin mismatched++; $display("FAIL rst_mid_timeout: valid=0, required a held beat within 5 cycles"); end
        reset = 1;
        step();
        reset = 0;
        out_ready = 1;
        compared++;
        if ({out_valid, busy, done, beat_count, checksum, out_reg, out_data} !== '0) begin
            mismatched++;
            $display("FAIL rst_mid_values: valid=%b busy=%b done=%b cnt=%0d cs=%h reg=%0d data=%h, required all 0",
                     out_valid, busy, done, beat_count, checksum, out_reg, out_data);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            compared++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL rst_mid_quiet: done=%b valid=%b after reset, required 0 and 0", done, out_valid);
            end
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 32; i++) write_rf(5'(i), $urandom());
        test_basic();
        test_wrap();
        test_full();
        test_backpressure();
        test_busy_start();
        test_write_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Serial reader for the 32 x 32-bit register file: on a start pulse it walks an inclusive, wrap-around range of register indices through the file's combinational read port. It presents each {index, value} pair on a valid/ready output stream for the debug/trace path. It also produces a beat count and an XOR checksum of the dumped words. It sits beside the datapath and drives one read port of `RegFile`; it never writes the file.

## Interface
- `ADDR_W`, 5, register index width (32 registers)
- `DATA_W`, 32, register data width
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE
- `first_reg`  in  ADDR_W  first index of the range, sampled with `start`
- `last_reg`  in  ADDR_W  last index of the range (inclusive), sampled with `start`
- `rf_read_reg`  out  ADDR_W  index driven to the register file read port
- `rf_read_data`  in  DATA_W  combinational read data returned for `rf_read_reg`
- `out_valid`  out  1  `out_reg`/`out_data` hold a beat
- `out_ready`  in  1  consumer accepts the beat when high together with `out_valid`
- `out_reg`  out  ADDR_W  index of the current beat
- `out_data`  out  DATA_W  register value of the current beat
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is left
- `done`  out  1  one-cycle pulse after the last beat is accepted
- `beat_count`  out  ADDR_W+1  number of beats accepted in the current/last dump
- `checksum`  out  DATA_W  XOR of all accepted `out_data`; stable from `done` until next `start`

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE: `start`=1 latches `ptr`<=`first_reg` and `end`<=`last_reg`, and clears `beat_count` and `checksum`. Next state is READ.
- READ: `rf_read_reg`=`ptr`. On the edge, `out_data`<=`rf_read_data` and `out_reg`<=`ptr`. Next state is HOLD.
- HOLD: `out_valid`=1, and the beat is held stable until accepted. When `out_ready`=1:
  - `checksum`^=`out_data` and `beat_count`+=1.
  - If `ptr`==`end`, next state is DONE.
  - Otherwise `ptr`<=`ptr`+1 (mod 32) and next state is READ.
- DONE: `done`=1 for exactly one cycle. Next state is IDLE.
- Range wraps modulo 32. Examples:
  - first=30, last=1 reads 30,31,0,1 (4 beats).
  - first==last gives 1 beat.
  - first=last+1 gives 32 beats, and `beat_count`=32 needs the extra bit.
- `start` in any state other than IDLE is ignored. Range inputs are not re-sampled.
- `rf_read_reg` holds `ptr` in every state; only the READ-cycle sample is meaningful.
- Concurrent writes:
  - A register file write to the same index on the READ-cycle edge is not visible in that beat; the old value is dumped.
  - Writes to indices not yet read are visible.
  - No snapshot consistency is provided.
- Register 0 is dumped like any other index, and its value is whatever the file returns.

## Timing
- Reset values: state IDLE, `out_valid`=0, `busy`=0, `done`=0, `out_reg`=0, `out_data`=0, `rf_read_reg`=0, `beat_count`=0, `checksum`=0.
- Reset mid-dump: the next cycle shows reset values, and the in-flight beat is dropped without `done`.
- `start` at edge N puts the FSM in READ in cycle N+1. `out_valid` rises in cycle N+2.
- Beat throughput is at most one per 2 cycles with `out_ready` held high.
- A dump of k beats with `out_ready` held high has `done` high in cycle N+2k+1.
- `out_valid` never drops without acceptance. `out_reg` and `out_data` are unchanged while `out_valid`=1 and `out_ready`=0.
- `checksum` and `beat_count` update on the accept edge and read final values in the `done` cycle.

## Structure
- Shared package `ca_pkg`:
  - `REG_COUNT`=32, `REG_ADDR_W`=5 and `REG_DATA_W`=32, shared with `RegFile`.
  - The `dump_state_t` enum (IDLE, READ, HOLD, DONE).
- Single flat module: FSM, wrap-around pointer, output register, and accumulators. No sub-module is warranted.
- Bench instantiates `regfile_dump` together with `RegFile`, with `rf_read_reg`/`rf_read_data` wired to read port 1.

## Test plan
- Preload r0..r3 with 0,55,7,9. Start first=0, last=3, `out_ready`=1:
  - Beats (0,0),(1,55),(2,7),(3,9) appear on cycles N+2,+4,+6,+8.
  - `done` is high at N+9 with `beat_count`=4 and `checksum`=55^7^9=57.
- Wrap: start first=30, last=1 -> `out_reg` sequence 30,31,0,1, and `beat_count`=4.
- Full range: start first=5, last=4 -> 32 beats, `beat_count`=32, and `out_reg` after 31 is 0.
- Backpressure: hold `out_ready`=0 for 5 cycles on beat (1,55). `out_valid`, `out_reg`=1 and `out_data`=55 stay stable, with no skipped or duplicated beat.
- Interference:
  - `start` asserted while busy does not change the range.
  - A write of 99 to r2 during the r1 HOLD is dumped as 99.
  - `reset` during HOLD -> `out_valid`=0, `busy`=0 next cycle, and no `done`.
